// File: rtl/axi_mem_slave_pkg.sv
// Shared widths, burst/response encodings and FSM state codes for axi_mem_slave.
package axi_mem_slave_pkg;

  localparam int ADDR_W = 40;
  localparam int DATA_W = 128;
  localparam int ID_W   = 8;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

endpackage

// File: rtl/axi_mem_slave_addr_gen.sv
// Next beat address for FIXED/INCR/WRAP bursts; shared by the read and write paths.
module axi_mem_slave_addr_gen
  import axi_mem_slave_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [2:0]        size_eff;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] wrap_mask;
  logic              wrap_ok;

  always_comb begin
    size_eff  = (size > 3'd4) ? 3'd4 : size;
    step      = ADDR_W'(1) << size_eff;
    incr      = addr + step;
    wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size_eff) - ADDR_W'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      // unsupported wrap lengths fall back to a plain increment
      BURST_WRAP:  next_addr = wrap_ok ? ((addr & ~wrap_mask) | (incr & wrap_mask)) : incr;
      default:     next_addr = incr;
    endcase
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI3-style memory responder serving one transaction at a time (FIXED/INCR/WRAP).
// Define AXI_MEM_SLAVE_DECERR_EN to answer out-of-range start addresses with DECERR.
module axi_mem_slave
  import axi_mem_slave_pkg::*;
#(
  parameter int                MEM_AW    = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 40'h0
) (
  input  logic              pll_core_cpuclk,
  input  logic              pad_cpu_rst_b,
  input  logic [ID_W-1:0]   biu_pad_arid,
  input  logic [ADDR_W-1:0] biu_pad_araddr,
  input  logic [7:0]        biu_pad_arlen,
  input  logic [2:0]        biu_pad_arsize,
  input  logic [1:0]        biu_pad_arburst,
  input  logic              biu_pad_arvalid,
  output logic              pad_biu_arready,
  input  logic [ID_W-1:0]   biu_pad_awid,
  input  logic [ADDR_W-1:0] biu_pad_awaddr,
  input  logic [7:0]        biu_pad_awlen,
  input  logic [2:0]        biu_pad_awsize,
  input  logic [1:0]        biu_pad_awburst,
  input  logic              biu_pad_awvalid,
  output logic              pad_biu_awready,
  input  logic [ID_W-1:0]   biu_pad_wid,
  input  logic [DATA_W-1:0] biu_pad_wdata,
  input  logic [STRB_W-1:0] biu_pad_wstrb,
  input  logic              biu_pad_wlast,
  input  logic              biu_pad_wvalid,
  output logic              pad_biu_wready,
  output logic [ID_W-1:0]   pad_biu_bid,
  output logic [1:0]        pad_biu_bresp,
  output logic              pad_biu_bvalid,
  input  logic              biu_pad_bready,
  output logic [ID_W-1:0]   pad_biu_rid,
  output logic [DATA_W-1:0] pad_biu_rdata,
  output logic [1:0]        pad_biu_rresp,
  output logic              pad_biu_rlast,
  output logic              pad_biu_rvalid,
  input  logic              biu_pad_rready
);

  // state   | meaning
  // IDLE    | arbitrating AR/AW, ready asserted for the selected channel
  // RD      | returning read beats
  // WR      | accepting write beats
  // WB      | presenting the write response

  logic [1:0]        state;
  logic              last_rd;
  logic [ID_W-1:0]   t_id;
  logic [ADDR_W-1:0] t_addr;
  logic [7:0]        t_len;
  logic [2:0]        t_size;
  logic [1:0]        t_burst;
  logic [7:0]        cnt;
  logic              werr;
  logic              derr;

  logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];

  logic              sel_rd, sel_wr, is_last, req_oob;
  logic [ADDR_W-1:0] next_addr, offset;
  logic [MEM_AW-1:0] widx;
  logic              unused_bits;

  assign sel_rd  = biu_pad_arvalid & (~biu_pad_awvalid | ~last_rd);
  assign sel_wr  = biu_pad_awvalid & ~sel_rd;
  assign is_last = (cnt == t_len);
  assign offset  = t_addr - BASE_ADDR;
  assign widx    = offset[MEM_AW+3:4];

`ifdef AXI_MEM_SLAVE_DECERR_EN
  logic [ADDR_W-1:0] req_addr, req_off;
  assign req_addr = sel_rd ? biu_pad_araddr : biu_pad_awaddr;
  assign req_off  = req_addr - BASE_ADDR;
  assign req_oob  = (req_addr < BASE_ADDR) || ((req_off >> (MEM_AW + 4)) != '0);
`else
  assign req_oob  = 1'b0;
`endif

  assign unused_bits = ^{biu_pad_wid, offset[ADDR_W-1:MEM_AW+4], offset[3:0]};

  axi_mem_slave_addr_gen u_addr_gen (
    .addr      (t_addr),
    .size      (t_size),
    .len       (t_len),
    .burst     (t_burst),
    .next_addr (next_addr)
  );

  // ready is gated by reset so nothing is offered while reset is held
  assign pad_biu_arready = pad_cpu_rst_b & (state == ST_IDLE) & sel_rd;
  assign pad_biu_awready = pad_cpu_rst_b & (state == ST_IDLE) & sel_wr;
  assign pad_biu_wready  = (state == ST_WR);
  assign pad_biu_rvalid  = (state == ST_RD);
  assign pad_biu_rid     = t_id;
  assign pad_biu_rdata   = (pad_biu_rvalid && !derr) ? mem[widx] : '0;
  assign pad_biu_rlast   = pad_biu_rvalid & is_last;
  assign pad_biu_rresp   = (pad_biu_rvalid && derr) ? RESP_DECERR : RESP_OKAY;
  assign pad_biu_bvalid  = (state == ST_WB);
  assign pad_biu_bid     = t_id;
  assign pad_biu_bresp   = !pad_biu_bvalid ? RESP_OKAY :
                           derr            ? RESP_DECERR :
                           werr            ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge pll_core_cpuclk) begin
    if (!pad_cpu_rst_b) begin
      state   <= ST_IDLE;
      last_rd <= 1'b0;
      t_id    <= '0;
      t_addr  <= '0;
      t_len   <= '0;
      t_size  <= '0;
      t_burst <= '0;
      cnt     <= '0;
      werr    <= 1'b0;
      derr    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_rd || sel_wr) begin
            t_id    <= sel_rd ? biu_pad_arid    : biu_pad_awid;
            t_addr  <= sel_rd ? biu_pad_araddr  : biu_pad_awaddr;
            t_len   <= sel_rd ? biu_pad_arlen   : biu_pad_awlen;
            t_size  <= sel_rd ? biu_pad_arsize  : biu_pad_awsize;
            t_burst <= sel_rd ? biu_pad_arburst : biu_pad_awburst;
            cnt     <= '0;
            werr    <= 1'b0;
            derr    <= req_oob;
            last_rd <= sel_rd;
            state   <= sel_rd ? ST_RD : ST_WR;
          end
        end
        ST_RD: begin
          if (biu_pad_rready) begin
            t_addr <= next_addr;
            cnt    <= cnt + 8'd1;
            if (is_last) state <= ST_IDLE;
          end
        end
        ST_WR: begin
          if (biu_pad_wvalid) begin
            t_addr <= next_addr;
            cnt    <= cnt + 8'd1;
            if (biu_pad_wlast != is_last) werr <= 1'b1;
            if (is_last) state <= ST_WB;
          end
        end
        ST_WB: begin
          if (biu_pad_bready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // memory has no reset so a mid-burst reset leaves its contents intact
  always_ff @(posedge pll_core_cpuclk) begin
    if (pad_cpu_rst_b && state == ST_WR && biu_pad_wvalid && !derr) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (biu_pad_wstrb[b]) mem[widx][b*8 +: 8] <= biu_pad_wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: stimulus pushes expected R/B responses, a monitor checks them.
module tb_axi_mem_slave;
  import axi_mem_slave_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b;
  logic [7:0] arid, awid, wid, rid, bid;
  logic [39:0] araddr, awaddr;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst, bresp, rresp;
  logic arvalid, awvalid, arready, awready;
  logic [127:0] wdata, rdata;
  logic [15:0] wstrb;
  logic wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

  axi_mem_slave dut (
    .pll_core_cpuclk(clk), .pad_cpu_rst_b(rst_b),
    .biu_pad_arid(arid), .biu_pad_araddr(araddr), .biu_pad_arlen(arlen),
    .biu_pad_arsize(arsize), .biu_pad_arburst(arburst), .biu_pad_arvalid(arvalid),
    .pad_biu_arready(arready),
    .biu_pad_awid(awid), .biu_pad_awaddr(awaddr), .biu_pad_awlen(awlen),
    .biu_pad_awsize(awsize), .biu_pad_awburst(awburst), .biu_pad_awvalid(awvalid),
    .pad_biu_awready(awready),
    .biu_pad_wid(wid), .biu_pad_wdata(wdata), .biu_pad_wstrb(wstrb),
    .biu_pad_wlast(wlast), .biu_pad_wvalid(wvalid), .pad_biu_wready(wready),
    .pad_biu_bid(bid), .pad_biu_bresp(bresp), .pad_biu_bvalid(bvalid),
    .biu_pad_bready(bready),
    .pad_biu_rid(rid), .pad_biu_rdata(rdata), .pad_biu_rresp(rresp),
    .pad_biu_rlast(rlast), .pad_biu_rvalid(rvalid), .biu_pad_rready(rready)
  );

  typedef struct { logic [7:0] id; logic [127:0] data; logic [1:0] resp; logic last; } r_exp_t;
  typedef struct { logic [7:0] id; logic [1:0] resp; } b_exp_t;

  r_exp_t exp_r[$];
  b_exp_t exp_b[$];
  logic [127:0] model [int];
  logic [39:0]  beat_addr [16];
  logic [127:0] beat_data [16];
  logic [15:0]  beat_strb [16];
  int checks = 0;
  int errors = 0;
  bit stall_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int word_of(input logic [39:0] a);
    return int'(a[17:4]);
  endfunction

  // monitor: pops the scoreboard on each handshake and checks stalled outputs hold
  logic prev_rstall, prev_bstall, prev_rlast;
  logic [127:0] prev_rdata;
  logic [7:0] prev_rid, prev_bid;
  logic [1:0] prev_bresp;
  r_exp_t er;
  b_exp_t eb;
  always @(negedge clk) begin
    if (rst_b !== 1'b1) begin
      prev_rstall = 1'b0;
      prev_bstall = 1'b0;
    end else begin
      if (prev_rstall) begin
        chk("r_hold_valid", 128'(rvalid), 128'(1'b1));
        chk("r_hold_data", rdata, prev_rdata);
        chk("r_hold_id_last", 128'({rid, rlast}), 128'({prev_rid, prev_rlast}));
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected actual rid=%h required none", rid);
        end else begin
          er = exp_r.pop_front();
          chk("rid", 128'(rid), 128'(er.id));
          chk("rdata", rdata, er.data);
          chk("rresp", 128'(rresp), 128'(er.resp));
          chk("rlast", 128'(rlast), 128'(er.last));
        end
      end
      prev_rstall = rvalid && !rready;
      prev_rdata = rdata; prev_rid = rid; prev_rlast = rlast;

      if (prev_bstall) begin
        chk("b_hold", 128'({bvalid, bid, bresp}), 128'({1'b1, prev_bid, prev_bresp}));
      end
      if (bvalid && bready) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected actual bid=%h required none", bid);
        end else begin
          eb = exp_b.pop_front();
          chk("bid", 128'(bid), 128'(eb.id));
          chk("bresp", 128'(bresp), 128'(eb.resp));
        end
      end
      prev_bstall = bvalid && !bready;
      prev_bid = bid; prev_bresp = bresp;
    end
  end

  initial begin
    rready = 1'b1;
    bready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      bready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic ar_req(input logic [7:0] id, input logic [39:0] a, input logic [7:0] len,
                        input logic [2:0] sz, input logic [1:0] bt);
    int n = 0;
    @(posedge clk); #1;
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = bt; arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    chk("ar_accept", 128'(arready), 128'(1'b1));
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic aw_req(input logic [7:0] id, input logic [39:0] a, input logic [7:0] len,
                        input logic [2:0] sz, input logic [1:0] bt);
    int n = 0;
    @(posedge clk); #1;
    awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bt; awvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!awready && n < 50);
    chk("aw_accept", 128'(awready), 128'(1'b1));
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_send(input int len, input int early);
    int n;
    for (int i = 0; i <= len; i++) begin
      wdata = beat_data[i]; wstrb = beat_strb[i]; wid = awid;
      wlast = (early >= 0) ? (i == early) : (i == len);
      wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!wready && n < 50);
      if (!wready) chk("w_accept", 128'(wready), 128'(1'b1));
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic drain(output int cyc);
    cyc = 0;
    while ((exp_r.size() != 0 || exp_b.size() != 0) && cyc < 300) begin
      @(posedge clk); cyc++;
    end
    chk("drain_pending", 128'(exp_r.size() + exp_b.size()), 128'(0));
  endtask

  task automatic model_write(input int len);
    logic [127:0] w;
    for (int i = 0; i <= len; i++) begin
      w = model.exists(word_of(beat_addr[i])) ? model[word_of(beat_addr[i])] : '0;
      for (int b = 0; b < 16; b++)
        if (beat_strb[i][b]) w[b*8 +: 8] = beat_data[i][b*8 +: 8];
      model[word_of(beat_addr[i])] = w;
    end
  endtask

  task automatic expect_read(input logic [7:0] id, input int len, input logic [1:0] resp);
    for (int i = 0; i <= len; i++)
      exp_r.push_back('{id, (resp == RESP_DECERR) ? 128'h0 : model[word_of(beat_addr[i])],
                        resp, (i == len)});
  endtask

  task automatic do_write(input logic [7:0] id, input logic [39:0] a, input int len,
                          input logic [2:0] sz, input logic [1:0] bt, input int early,
                          input logic [1:0] resp);
    int cyc;
    exp_b.push_back('{id, resp});
    if (resp != RESP_DECERR) model_write(len);
    aw_req(id, a, 8'(len), sz, bt);
    w_send(len, early);
    drain(cyc);
  endtask

  task automatic do_read(input logic [7:0] id, input logic [39:0] a, input int len,
                         input logic [2:0] sz, input logic [1:0] bt, input logic [1:0] resp,
                         output int cyc);
    expect_read(id, len, resp);
    ar_req(id, a, 8'(len), sz, bt);
    drain(cyc);
  endtask

  task automatic fill_incr(input logic [39:0] a, input int len, input logic [31:0] tag);
    for (int i = 0; i <= len; i++) begin
      beat_addr[i] = a + 40'(16 * i);
      beat_data[i] = {4{tag | 32'(i)}};
      beat_strb[i] = 16'hFFFF;
    end
  endtask

  initial begin
    #400000;
    checks++; errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  int cyc;
  int n;

  initial begin
    rst_b = 1'b0;
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b0; wlast = 1'b0;
    arid = 8'h7; awid = 8'h9; araddr = '0; awaddr = '0; arlen = '0; awlen = '0;
    arsize = 3'd4; awsize = 3'd4; arburst = BURST_INCR; awburst = BURST_INCR;
    wid = '0; wdata = '0; wstrb = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 128'({arready, awready, wready}), 128'(3'b000));
    chk("rst_valid", 128'({rvalid, bvalid, rlast}), 128'(3'b000));
    chk("rst_payload", 128'({rid, bid, rresp, bresp}), 128'(0));
    chk("rst_rdata", rdata, 128'h0);
    arvalid = 1'b0; awvalid = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;

    // single-beat write then read
    beat_addr[0] = 40'h100; beat_data[0] = {16{8'hA5}}; beat_strb[0] = 16'hFFFF;
    do_write(8'h1, 40'h100, 0, 3'd4, BURST_INCR, -1, RESP_OKAY);
    do_read(8'h3, 40'h100, 0, 3'd4, BURST_INCR, RESP_OKAY, cyc);

    // INCR burst, full throughput
    fill_incr(40'h1000, 3, 32'hC0DE_0000);
    do_write(8'h11, 40'h1000, 3, 3'd4, BURST_INCR, -1, RESP_OKAY);
    do_read(8'h12, 40'h1000, 3, 3'd4, BURST_INCR, RESP_OKAY, cyc);
    chk("incr_throughput_cycles", 128'(cyc), 128'(4));

    // WRAP burst: 0x1020, 0x1030, 0x1000, 0x1010
    beat_addr[0] = 40'h1020; beat_addr[1] = 40'h1030;
    beat_addr[2] = 40'h1000; beat_addr[3] = 40'h1010;
    for (int i = 0; i < 4; i++) begin
      beat_data[i] = {4{32'hBEEF_0000 | 32'(i)}};
      beat_strb[i] = 16'hFFFF;
    end
    do_write(8'h21, 40'h1020, 3, 3'd4, BURST_WRAP, -1, RESP_OKAY);
    do_read(8'h22, 40'h1020, 3, 3'd4, BURST_WRAP, RESP_OKAY, cyc);
    fill_incr(40'h1000, 3, 32'h0);
    do_read(8'h23, 40'h1000, 3, 3'd4, BURST_INCR, RESP_OKAY, cyc);

    // random rready/bready stalls
    stall_en = 1'b1;
    fill_incr(40'h2000, 3, 32'h5A5A_0000);
    do_write(8'h31, 40'h2000, 3, 3'd4, BURST_INCR, -1, RESP_OKAY);
    do_read(8'h32, 40'h2000, 3, 3'd4, BURST_INCR, RESP_OKAY, cyc);
    beat_addr[0] = 40'h100;
    do_read(8'h33, 40'h100, 0, 3'd4, BURST_FIXED, RESP_OKAY, cyc);
    stall_en = 1'b0;
    @(posedge clk); #1;

    // partial strobe onto a pre-filled word
    beat_addr[0] = 40'h200; beat_data[0] = {16{8'h11}}; beat_strb[0] = 16'hFFFF;
    do_write(8'h41, 40'h200, 0, 3'd4, BURST_INCR, -1, RESP_OKAY);
    beat_data[0] = {16{8'hEE}}; beat_strb[0] = 16'h000F;
    do_write(8'h42, 40'h200, 0, 3'd4, BURST_INCR, -1, RESP_OKAY);
    chk("partial_model", model[word_of(40'h200)], {{12{8'h11}}, {4{8'hEE}}});
    do_read(8'h43, 40'h200, 0, 3'd4, BURST_INCR, RESP_OKAY, cyc);

    // early wlast on beat 2 of a 4-beat write
    fill_incr(40'h3000, 3, 32'h7777_0000);
    do_write(8'h51, 40'h3000, 3, 3'd4, BURST_INCR, 1, RESP_SLVERR);
    do_read(8'h52, 40'h3000, 3, 3'd4, BURST_INCR, RESP_OKAY, cyc);

`ifdef AXI_MEM_SLAVE_DECERR_EN
    beat_addr[0] = 40'h0; beat_data[0] = {4{32'h600D_F00D}}; beat_strb[0] = 16'hFFFF;
    do_write(8'h61, 40'h0, 0, 3'd4, BURST_INCR, -1, RESP_OKAY);
    do_read(8'h62, 40'h400_0000, 1, 3'd4, BURST_INCR, RESP_DECERR, cyc);
    beat_addr[0] = 40'h400_0000; beat_data[0] = {16{8'hDD}};
    do_write(8'h63, 40'h400_0000, 0, 3'd4, BURST_INCR, -1, RESP_DECERR);
    beat_addr[0] = 40'h0;
    do_read(8'h64, 40'h0, 0, 3'd4, BURST_INCR, RESP_OKAY, cyc);
`else
    beat_addr[0] = 40'h400_0040; beat_data[0] = {4{32'hA11A_5000}}; beat_strb[0] = 16'hFFFF;
    do_write(8'h61, 40'h400_0040, 0, 3'd4, BURST_INCR, -1, RESP_OKAY);
    beat_addr[0] = 40'h40;
    do_read(8'h62, 40'h40, 0, 3'd4, BURST_INCR, RESP_OKAY, cyc);
`endif

    // reset in the middle of a read burst
    fill_incr(40'h2000, 3, 32'h5A5A_0000);
    expect_read(8'h71, 3, RESP_OKAY);
    ar_req(8'h71, 40'h2000, 8'd3, 3'd4, BURST_INCR);
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_rvalid", 128'({rvalid, rlast}), 128'(2'b00));
    chk("midrst_idle_ready", 128'({arready, awready, wready, bvalid}), 128'(4'b0000));
    exp_r.delete();
    @(posedge clk); #1;
    rst_b = 1'b1;
    do_read(8'h72, 40'h2000, 3, 3'd4, BURST_INCR, RESP_OKAY, cyc);
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;

    // simultaneous AR and AW after reset: read first, then write
    beat_addr[0] = 40'h100;
    expect_read(8'h05, 0, RESP_OKAY);
    beat_addr[0] = 40'h5000; beat_data[0] = {4{32'h1234_5678}}; beat_strb[0] = 16'hFFFF;
    model_write(0);
    exp_b.push_back('{8'h06, RESP_OKAY});
    @(posedge clk); #1;
    arid = 8'h05; araddr = 40'h100; arlen = 8'd0; arsize = 3'd4; arburst = BURST_INCR;
    awid = 8'h06; awaddr = 40'h5000; awlen = 8'd0; awsize = 3'd4; awburst = BURST_INCR;
    arvalid = 1'b1; awvalid = 1'b1;
    @(negedge clk);
    chk("both_arready", 128'(arready), 128'(1'b1));
    chk("both_awready", 128'(awready), 128'(1'b0));
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 50);
    chk("aw_after_read", 128'(awready), 128'(1'b1));
    chk("read_done_before_aw", 128'(exp_r.size()), 128'(0));
    @(posedge clk); #1;
    awvalid = 1'b0;
    w_send(0, -1);
    drain(cyc);
    do_read(8'h07, 40'h5000, 0, 3'd4, BURST_INCR, RESP_OKAY, cyc);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
